// File: rtl/icache_responder.sv
// Direct-mapped, flop-based instruction cache that answers fetch requests and
// refills missing lines from a beat-oriented 32-bit memory port.
module icache_responder #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_re,
    output logic [31:0] icache_dout,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] access_count,
    output logic [31:0] miss_count
);

    localparam int unsigned WB = $clog2(LINE_WORDS);
    localparam int unsigned O  = WB + 2;
    localparam int unsigned I  = $clog2(NUM_LINES);
    localparam int unsigned TW = 32 - O - I;
    localparam logic [WB-1:0] BEAT_LAST = WB'(LINE_WORDS - 1);
    localparam logic [WB-1:0] BEAT_ONE  = WB'(1);

    typedef enum logic [1:0] {RUN, MISS_REQ, MISS_DATA} state_t;

    state_t                state_q;
    logic                  pend_q;
    logic                  flush_pend_q;
    logic [31:0]           req_addr_q;
    logic [31:0]           mem_req_addr_q;
    logic [31:0]           access_q;
    logic [31:0]           miss_q;
    logic [WB-1:0]         beat_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TW-1:0]         tag_q  [NUM_LINES];
    logic [31:0]           data_q [NUM_LINES][LINE_WORDS];

    logic [WB-1:0] req_word;
    logic [I-1:0]  req_idx;
    logic [TW-1:0] req_tag;
    logic          hit;
    logic          deliver;

    assign req_word = req_addr_q[O-1:2];
    assign req_idx  = req_addr_q[O+I-1:O];
    assign req_tag  = req_addr_q[31:O+I];

    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign deliver = (state_q == RUN) && pend_q && hit;

    // stall depends only on registered state, never on icache_re
    assign stall         = (state_q != RUN) || (pend_q && !hit);
    assign icache_dout   = deliver ? data_q[req_idx][req_word] : NOP_INST;
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = mem_req_addr_q;
    assign access_count  = access_q;
    assign miss_count    = miss_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            pend_q         <= 1'b0;
            flush_pend_q   <= 1'b0;
            req_addr_q     <= '0;
            mem_req_addr_q <= '0;
            access_q       <= '0;
            miss_q         <= '0;
            beat_q         <= '0;
            valid_q        <= '0;
        end else begin
            if (!stall) begin
                pend_q <= icache_re;
                if (icache_re) begin
                    req_addr_q <= icache_addr;
                end
            end

            case (state_q)
                RUN: begin
                    // a flush seen during a refill is applied after the refilled word is delivered
                    if (flush || flush_pend_q) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end
                    if (pend_q) begin
                        if (hit) begin
                            access_q <= access_q + 32'd1;
                        end else begin
                            miss_q         <= miss_q + 32'd1;
                            mem_req_addr_q <= {req_addr_q[31:O], {O{1'b0}}};
                            state_q        <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        beat_q  <= '0;
                        state_q <= MISS_DATA;
                    end
                end
                MISS_DATA: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        beat_q <= beat_q + BEAT_ONE;
                        if (beat_q == BEAT_LAST) begin
                            valid_q[req_idx] <= 1'b1;
                            state_q          <= RUN;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Storage arrays carry no reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (state_q == MISS_DATA && mem_resp_valid) begin
            data_q[req_idx][beat_q] <= mem_resp_data;
            if (beat_q == BEAT_LAST) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder serving the fetch stage's `icache_addr` / `icache_re` requests.
- Returns `icache_dout` and drives the `stall` signal back into the pipeline.
- Direct-mapped, flop-based cache. Misses are refilled from a 32-bit beat-oriented memory port.
- Sits between the Stage 1 fetch logic and the main-memory arbiter.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2, ≥2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- NOP_INST, 32'h0000_0013, instruction driven on `icache_dout` when no word is delivered.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- icache_addr  in  32  byte address of fetch; bits [1:0] ignored.
- icache_re  in  1  fetch request; sampled only when `stall`=0.
- icache_dout  out  32  returned instruction.
- stall  out  1  pipeline stall; pending fetch not yet delivered.
- flush  in  1  invalidate all lines (single-cycle pulse).
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  line-aligned byte address of refill.
- mem_resp_valid  in  1  one refill beat valid.
- mem_resp_data  in  32  refill beat, in ascending word order.
- access_count  out  32  words delivered (wraps).
- miss_count  out  32  misses taken (wraps).

Behaviour:
- Address split (O = log2(LINE_WORDS)+2, I = log2(NUM_LINES)):
  - word = addr[O-1:2]
  - index = addr[O+I-1:O]
  - tag = addr[31:O+I]
- State: valid[NUM_LINES], tag array, data array (flops); pend, req_addr registers; FSM {RUN, MISS_REQ, MISS_DATA}; beat counter.
- Reset (async):
  - all valid bits cleared; pend=0; state=RUN; beat=0; flush_pend=0; counters=0.
  - outputs: stall=0, mem_req_valid=0, mem_req_addr=0, icache_dout=NOP_INST.
- Request capture:
  - on a clock edge with stall=0 and icache_re=1: req_addr←icache_addr, pend←1.
  - stall=0 and icache_re=0: pend←0.
  - stall=1: request registers hold and the input is ignored.
- Latency: a hit delivers the word in the cycle after capture (SRAM-like, 1 cycle).
- RUN, pend=1, hit (valid[index] && tag match):
  - icache_dout = data[index][word]; stall=0; access_count+1.
- RUN, pend=1, miss:
  - stall=1; icache_dout=NOP_INST; miss_count+1; next state MISS_REQ.
- RUN, pend=0: stall=0; icache_dout=NOP_INST.
- MISS_REQ:
  - mem_req_valid=1; mem_req_addr = {req_addr[31:O], O'b0}; stall=1.
  - on mem_req_ready → MISS_DATA, beat←0.
  - mem_req_valid/addr stay stable until accepted.
- MISS_DATA:
  - stall=1; each mem_resp_valid writes data[index][beat] and increments beat.
  - on the beat LINE_WORDS-1: write tag, set valid[index], → RUN.
  - The following RUN cycle then hits: word delivered, stall=0.
  - Miss-to-delivery = 1 + handshake cycles + beat cycles + 1.
- mem_resp_valid outside MISS_DATA is ignored.
- Combinational outputs: stall = (state≠RUN) || (pend && !hit). No combinational path from icache_re to stall.
- Flush:
  - In RUN: all valid bits clear at the edge. A lookup in the same cycle uses pre-flush contents.
  - In MISS_*: latched into flush_pend and applied in the first RUN cycle. The refilled word is still delivered that cycle, then invalidated.
- Reset mid-refill: abort; the partially written line stays invalid; late memory beats are ignored.
- Counters wrap from 32'hFFFF_FFFF to 0.
- Simultaneous: stall=0 delivery and a new icache_re capture occur in the same cycle (back-to-back hits, 1 word per cycle).

Test Plan:
- Reset, then re=1 at addr 0x100; memory grants ready after 2 cycles and returns beats 0xA0..0xA3 → stall=1 through refill; the next cycle gives dout=0xA0, stall=0, miss_count=1, access_count=1.
- After the fill, back-to-back re at 0x104, 0x108, 0x10C → dout 0xA1, 0xA2, 0xA3 on consecutive cycles, stall=0, miss_count stays 1.
- Conflict: addr 0x100 then 0x200 (same index, different tag, 16 lines×16B) → second access misses, mem_req_addr=0x200; re-reading 0x100 misses again (miss_count=3).
- Flush pulse during MISS_DATA for 0x300 → word for 0x300 delivered; a subsequent read of 0x300 misses again.
- Assert reset after 2 of 4 beats → stall=0, dout=NOP_INST, counters=0; remaining beats ignored; a re-request of the same line misses and fully refills.
- stall=1 while icache_re toggles and icache_addr changes → mem_req_addr unaffected; the delivered word belongs to the originally captured address.
